// File: rtl/lsu_stage_pkg.sv
// Shared encodings for the load/store stage: FSM states, access sizes
// and the funct3 bit that selects unsigned loads.
package lsu_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int F3_UNS = 2;

  // funct3[1:0] of 10 and 11 both mean a full word
  function automatic logic is_word(input logic [1:0] size);
    return (size == SZ_W) || (size == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Data-memory request/acknowledge bus between the load/store stage
// (master) and the data memory (slave).
interface lsu_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/lsu_stage_align.sv
// Combinational lane logic: store replication/byte enables, the
// misalignment check, and load byte/half extraction with extension.
module lsu_align
  import lsu_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic        mis,
  input  logic [1:0]  ld_size,
  input  logic        ld_uns,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
    return uns ? {24'b0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
    return uns ? {16'b0, h} : {{16{h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_wdata = store_data;
    st_be    = 4'b1111;
    mis      = 1'b0;
    if (size == SZ_B) begin
      st_wdata = {4{store_data[7:0]}};
      st_be    = 4'b0001 << off;
    end else if (size == SZ_H) begin
      st_wdata = {2{store_data[15:0]}};
      st_be    = off[1] ? 4'b1100 : 4'b0011;
      mis      = off[0];
    end else begin
      mis      = (off != 2'b00);
    end
  end

  // Lane choice uses the offset captured at accept, not the live address
  always_comb begin
    byte_sel = rdata[{ld_off, 3'b000} +: 8];
    half_sel = ld_off[1] ? rdata[31:16] : rdata[15:0];
    if (is_word(ld_size))
      ld_data = rdata;
    else if (ld_size == SZ_H)
      ld_data = ext16(half_sel, ld_uns);
    else
      ld_data = ext8(byte_sel, ld_uns);
  end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access stage: issues one data-memory transaction per accepted
// load/store, stalls the core while it is outstanding, aborts on timeout.
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluResult,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic        done,
  output logic [31:0] loadData,
  output logic        misalign,
  output logic        timeoutErr,
  lsu_stage_if.master dmem
);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;

  logic        is_mem;
  logic        mis;
  logic        acc;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  lsu_align u_align (
    .size       (funct3[1:0]),
    .off        (aluResult[1:0]),
    .store_data (storeData),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .mis        (mis),
    .ld_size    (funct3_q[1:0]),
    .ld_uns     (funct3_q[F3_UNS]),
    .ld_off     (off_q),
    .rdata      (dmem.dmem_rdata),
    .ld_data    (ld_data)
  );

  assign is_mem   = memRead | memWrite;
  assign acc      = is_mem & ~mis;
  assign misalign = (state == IDLE) & is_mem & mis;

  // Reset forces stall low at once so the core is not frozen by a dead access
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = acc;
      REQ:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      funct3_q        <= '0;
      off_q           <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      loadData        <= '0;
      done            <= 1'b0;
      timeoutErr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          timeoutErr <= 1'b0;
          cnt        <= '0;
          if (acc) begin
            // Both strobes high is a store
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= memWrite;
            dmem.dmem_addr  <= {aluResult[31:2], 2'b00};
            dmem.dmem_wdata <= st_wdata;
            dmem.dmem_be    <= memWrite ? st_be : 4'b1111;
            funct3_q        <= funct3;
            off_q           <= aluResult[1:0];
            state           <= REQ;
          end
        end
        REQ: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            loadData      <= dmem.dmem_we ? 32'd0 : ld_data;
            done          <= 1'b1;
            state         <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            dmem.dmem_req <= 1'b0;
            loadData      <= 32'd0;
            done          <= 1'b1;
            timeoutErr    <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          done       <= 1'b0;
          timeoutErr <= 1'b0;
          cnt        <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Memory-access stage directly downstream of the ALU.
- Takes the ALU result as the effective address, plus store data and control from decode.
- Runs a req/ack handshake with data memory and returns aligned, sign- or zero-extended load data for writeback.
- Asserts a combinational stall so the single-cycle core freezes the PC while a memory access is outstanding.

Parameters:
- TIMEOUT, 255: cycles to wait in REQ for dmem_ack before aborting the access.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- memRead  in  1  load request from decode.
- memWrite  in  1  store request from decode.
- funct3  in  3  access size/sign: [1:0] 00=byte, 01=half, 10/11=word; [2] 1=unsigned load.
- aluResult  in  32  effective byte address from the ALU.
- storeData  in  32  rs2 value for stores.
- stall  out  1  freeze PC/regfile write; combinational.
- done  out  1  one-cycle pulse: access complete, loadData valid.
- loadData  out  32  extended load result, registered.
- misalign  out  1  combinational: current request is misaligned, no access issued.
- timeoutErr  out  1  one-cycle pulse coincident with done when the access aborted.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1=write.
- dmem_addr  out  32  word address, {aluResult[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  memory completes request; sampled only in REQ.
- dmem_rdata  in  32  read word, valid with dmem_ack.

Behaviour:
- Reset:
  - State goes to IDLE and the counter clears.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, loadData, done and timeoutErr all go to 0.
  - Reset mid-transaction drops dmem_req immediately; the memory must tolerate an abandoned request.
- States: IDLE, REQ, RESP.
- Accept condition: acc = (memRead|memWrite) & ~misalign.
- IDLE:
  - If acc: latch the dmem_* outputs, funct3 and addr[1:0]; set dmem_req=1 and go to REQ.
  - stall = acc (combinational, in the same cycle).
- REQ:
  - stall=1 and dmem_req held at 1.
  - On dmem_ack=1 at the clock edge:
    - Read: loadData = extract(dmem_rdata).
    - Write: loadData = 0.
    - In both cases dmem_req goes to 0 and the state goes to RESP.
  - Otherwise the counter increments. At counter==TIMEOUT-1 with no ack: dmem_req goes to 0, loadData=0, timeoutErr=1, state goes to RESP.
- RESP:
  - done=1, stall=0; the core advances at the end of this cycle.
  - memRead/memWrite are ignored in RESP.
  - Next state is IDLE; done and timeoutErr clear and the counter clears.
- Minimum latency:
  - An ack in the first REQ cycle gives 3 cycles from the IDLE accept to the end of RESP.
  - Back-to-back accesses: the next accept is possible in the cycle after RESP.
- Misalignment:
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, sets misalign=1.
  - No request is issued, stall=0, and the state stays in IDLE.
- memRead and memWrite both high: treated as a write.
- Store lanes:
  - Byte: be = 4'b0001 << addr[1:0], wdata = {4{storeData[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011, wdata = {2{storeData[15:0]}}.
  - Word: be = 1111, wdata = storeData.
  - Loads drive be=1111 and dmem_we=0.
- Load extraction:
  - Byte lane is selected by the latched addr[1:0]; half lane by addr[1].
  - Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
- dmem_ack outside REQ is ignored.
- Inputs are not re-sampled during REQ; changes on the core side have no effect until RESP.

Decomposition:
- Shared package/include holds:
  - State encodings (IDLE=2'd0, REQ=2'd1, RESP=2'd2).
  - Size constants (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10).
  - The funct3 unsigned-bit index.
- One combinational sub-module, lsu_align, contains:
  - Store lane replication and byte-enable generation.
  - The misalign check.
  - Load byte/half extraction with extension.
- FSM, timeout counter and registers stay in lsu_stage.

Test Plan:
- LW at 0x0000_0100, memory acks on 1st REQ cycle with rdata 0xDEAD_BEEF -> dmem_addr=0x100, be=1111; stall high 2 cycles; done pulse with loadData=0xDEAD_BEEF.
- LB at 0x103, rdata 0x80FF_0000, then LBU at 0x103 -> loadData=0xFFFF_FF80, then 0x0000_0080.
- SH at 0x0000_0006 with storeData 0x1234_ABCD -> be=1100, wdata=0xABCD_ABCD, dmem_we=1; done pulse with loadData=0.
- LW at 0x102 -> misalign=1, stall=0, dmem_req stays 0, state stays IDLE.
- LW, ack withheld -> after 255 REQ cycles dmem_req drops, timeoutErr and done pulse together, loadData=0.
- rst asserted in the 3rd REQ cycle -> dmem_req and stall drop without a clock edge; a later ack is ignored; next LW completes normally.
